ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 1024x8 RAM (ports clock/address/data/wren/q) between two requesters: A (game/control logic) and B (display scanner).
- One RAM access per cycle, granted by a round-robin or fixed-priority arbiter.
- Returns read data to the requester that issued the read.
- Contains a clear sequencer that fills the whole RAM with a constant after reset or on command, before normal service starts.

Parameters:
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, cycles from RAM address capture to valid ram_q; legal range 1..3.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to SERVE.
- CLEAR_VALUE, 8'h00, word written to every address during clear.
- PRIORITY_A, 0, 0 = round-robin on ties; 1 = A always wins ties.

Ports:
- clock in 1: system clock, rising edge.
- reset in 1: synchronous, active-high.
- clear in 1: one-cycle pulse that requests a full RAM clear.
- busy out 1: high while in CLEAR.
- req_a / req_b in 1: access request; held until granted.
- we_a / we_b in 1: 1 = write, 0 = read; held with req.
- addr_a / addr_b in ADDR_W: access address; held with req.
- wdata_a / wdata_b in DATA_W: write data; held with req.
- gnt_a / gnt_b out 1: access issued to the RAM this cycle.
- rvalid_a / rvalid_b out 1: one-cycle pulse, read data valid.
- rdata_a / rdata_b out DATA_W: read data; meaningful only while rvalid is high.
- ram_address out ADDR_W: to RAM address.
- ram_data out DATA_W: to RAM data.
- ram_wren out 1: to RAM wren.
- ram_q in DATA_W: from RAM q.

Behaviour:
- Reset:
  - State = CLEAR if CLEAR_ON_RESET, else SERVE. Clear counter = 0.
  - Round-robin pointer = "last granted B", so A wins the first tie.
  - Read pipeline flushed; rvalid_a/b = 0; rdata_a/b = 0.
  - While reset is high: ram_wren = 0, gnt_a/b = 0, ram_address = 0, ram_data = 0.
  - Reset mid-clear restarts the clear at address 0. Reset drops any in-flight read without an rvalid.
- CLEAR state:
  - busy = 1. Each cycle: ram_wren = 1, ram_address = counter, ram_data = CLEAR_VALUE; counter increments.
  - The write at counter = DEPTH-1 is the last one; the next cycle is SERVE. Exactly DEPTH write cycles.
  - gnt_a/b = 0 throughout. Requests stay pending and are not lost. clear is ignored.
- SERVE state:
  - busy = 0. Grant logic is combinational in the same cycle.
  - Only one requester asserting req: that requester is granted.
  - Both asserting, PRIORITY_A = 0: grant the requester not granted most recently. Pointer updates only on a grant.
  - Both asserting, PRIORITY_A = 1: grant A.
  - Grant cycle: ram_address/ram_data/ram_wren are taken from the winner; ram_wren = winner's we. gnt of the winner = 1 for that cycle only.
  - Requester may change or drop its signals in the cycle after gnt. Back-to-back grants to the same requester are allowed.
  - No request: ram_wren = 0; ram_address/ram_data hold their last values.
  - clear high in SERVE: that cycle is still arbitrated normally, and the state moves to CLEAR on the next cycle.
- Read return:
  - A read granted in cycle T has ram_q valid in cycle T+RD_LATENCY. The arbiter registers it at the end of that cycle.
  - rvalid_x = 1 and rdata_x = ram_q during cycle T+RD_LATENCY+1 (T+2 at default).
  - Implemented as a RD_LATENCY-deep tag pipeline {valid, id}. At most one rvalid per cycle, returned in issue order.
  - Writes produce no rvalid.
  - The pipeline runs independently of state: reads issued before a clear still return, with data read before the clear overwrote the location.
- No write-to-read forwarding. A read granted the cycle after a write to the same address returns the new data.
- Address width rules: no wrap; addresses are used as-is. The clear counter is ADDR_W+1 bits wide so that DEPTH-1 is detected without aliasing.

Test Plan:
1. Reset released with CLEAR_ON_RESET=1 -> busy high exactly 1024 cycles; ram_wren=1 and ram_address=0..1023 in order with ram_data=8'h00; then a B read of 10'h005 returns rdata_b=8'h00.
2. A writes 8'h3C to 10'h155 (gnt_a in cycle T), then B reads 10'h155 -> gnt_b in cycle T+1, rvalid_b=1 with rdata_b=8'h3C in cycle T+3, rvalid_a stays 0.
3. PRIORITY_A=0, A and B both reading continuously from 10'h010/10'h020 -> grants alternate A,B,A,B… starting with A, a grant every cycle, and each rvalid carries its own requester's data.
4. PRIORITY_A=1, both requesting for 6 cycles, then A drops req -> gnt_a for 6 cycles, gnt_b=0 during them, gnt_b=1 in the first cycle after A drops.
5. Read by A of 10'h0AA (holding 8'h77) granted in the same cycle clear is pulsed -> rvalid_a with 8'h77 two cycles later; busy=1 for 1024 cycles; req_b held during clear gets gnt_b only in the first SERVE cycle.
6. reset asserted for one cycle when clear counter=500 -> rvalid outputs 0, clear restarts at ram_address=0, busy stays high a further 1024 cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between requester A (control logic)
// and requester B (display scanner). One access per cycle. Read data is routed
// back to whichever requester issued the read. A clear sequencer fills the RAM
// with CLEAR_VALUE after reset (optional) and whenever clear is pulsed.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | writing CLEAR_VALUE to every address, requesters held off
// ST_SERVE | arbitrating A/B requests, one RAM access per cycle
module ram_arbiter #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 8,
    parameter int                RD_LATENCY     = 1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                PRIORITY_A     = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    // Counter is one bit wider than the address so the last address compares
    // cleanly without wrapping back to zero.
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_SERVE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      clr_cnt;
    logic                  last_b;
    logic                  pick_a;
    logic                  rd_issue;
    logic [ADDR_W-1:0]     hold_addr;
    logic [DATA_W-1:0]     hold_data;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [RD_LATENCY-1:0] pipe_id;

    // Next state, grant decision and RAM port drive
    always_comb begin
        state_nxt   = state;
        busy        = (state == ST_CLEAR);
        gnt_a       = 1'b0;
        gnt_b       = 1'b0;
        ram_wren    = 1'b0;
        ram_address = hold_addr;
        ram_data    = hold_data;
        // A wins when alone, when A has fixed priority, or when B went last.
        pick_a      = req_a && (!req_b || PRIORITY_A || last_b);
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                state_nxt = ST_CLEAR;
            end else begin
                state_nxt = ST_SERVE;
            end
            ram_address = '0;
            ram_data    = '0;
        end else if (state == ST_CLEAR) begin
            ram_wren    = 1'b1;
            ram_address = clr_cnt[ADDR_W-1:0];
            ram_data    = CLEAR_VALUE;
            if (clr_cnt == CLR_LAST) begin
                state_nxt = ST_SERVE;
            end
        end else begin
            gnt_a = pick_a;
            gnt_b = req_b && !pick_a;
            if (gnt_a) begin
                ram_wren    = we_a;
                ram_address = addr_a;
                ram_data    = wdata_a;
            end else if (gnt_b) begin
                ram_wren    = we_b;
                ram_address = addr_b;
                ram_data    = wdata_b;
            end
            if (clear) begin
                state_nxt = ST_CLEAR;
            end
        end
    end

    assign rd_issue = (gnt_a && !we_a) || (gnt_b && !we_b);

    // State register and clear address counter
    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                state <= ST_CLEAR;
            end else begin
                state <= ST_SERVE;
            end
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR && clr_cnt != CLR_LAST) begin
                clr_cnt <= clr_cnt + CNT_W'(1);
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // Round-robin pointer and hold of the last driven RAM address/data
    always_ff @(posedge clock) begin
        if (reset) begin
            last_b    <= 1'b1;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            if (gnt_a) begin
                last_b <= 1'b0;
            end else if (gnt_b) begin
                last_b <= 1'b1;
            end
            hold_addr <= ram_address;
            hold_data <= ram_data;
        end
    end

    // Read tag pipeline: tracks which requester owns ram_q once it is valid
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= rd_issue;
            pipe_id[0] <= gnt_b;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    // Capture ram_q into the owning requester's return register
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= pipe_v[RD_LATENCY-1] && !pipe_id[RD_LATENCY-1];
            rvalid_b <= pipe_v[RD_LATENCY-1] && pipe_id[RD_LATENCY-1];
            if (pipe_v[RD_LATENCY-1] && !pipe_id[RD_LATENCY-1]) begin
                rdata_a <= ram_q;
            end
            if (pipe_v[RD_LATENCY-1] && pipe_id[RD_LATENCY-1]) begin
                rdata_b <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM, directed scenarios and random
// traffic checked every cycle against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int          AW    = 10;
    localparam int          DW    = 8;
    localparam int          DEPTH = 1024;
    localparam logic [7:0]  CV    = 8'h00;

    logic          clk = 1'b0;
    logic          reset, clear, req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          busy, gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wren;
    logic [DW-1:0] rdata_a, rdata_b, ram_data, ram_q;
    logic [AW-1:0] ram_address;

    logic          pa_reset, pa_req_a, pa_req_b;
    logic          pa_busy, pa_gnt_a, pa_gnt_b, pa_rvalid_a, pa_rvalid_b, pa_ram_wren;
    logic [DW-1:0] pa_rdata_a, pa_rdata_b, pa_ram_data, pa_ram_q;
    logic [AW-1:0] pa_ram_address;

    int n_vec = 0;
    int n_err = 0;

    // Clock generation
    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1),
                  .CLEAR_VALUE(CV), .PRIORITY_A(1'b0)) u_dut (
        .clock(clk), .reset(reset), .clear(clear), .busy(busy),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q));

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0),
                  .CLEAR_VALUE(CV), .PRIORITY_A(1'b1)) u_dut_pa (
        .clock(clk), .reset(pa_reset), .clear(1'b0), .busy(pa_busy),
        .req_a(pa_req_a), .we_a(1'b0), .addr_a(10'h011), .wdata_a(8'h00),
        .gnt_a(pa_gnt_a), .rvalid_a(pa_rvalid_a), .rdata_a(pa_rdata_a),
        .req_b(pa_req_b), .we_b(1'b0), .addr_b(10'h022), .wdata_b(8'h00),
        .gnt_b(pa_gnt_b), .rvalid_b(pa_rvalid_b), .rdata_b(pa_rdata_b),
        .ram_address(pa_ram_address), .ram_data(pa_ram_data), .ram_wren(pa_ram_wren),
        .ram_q(pa_ram_q));

    // Behavioural single-port RAM with one cycle read latency
    logic [7:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    // Reference model state
    typedef struct {
        int         due;
        bit         id;
        logic [7:0] data;
    } ret_t;

    logic [7:0] mem_ref [0:DEPTH-1];
    ret_t       rq[$];
    int         cyc;
    bit         m_clr;
    int         m_cnt;
    bit         m_last_b;
    logic [9:0] m_haddr;
    logic [7:0] m_hdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_clr    = 1'b1;
        m_cnt    = 0;
        m_last_b = 1'b1;
        m_haddr  = '0;
        m_hdata  = '0;
        rq.delete();
    endtask

    // One clock cycle: inputs are already driven; check, advance model, clock.
    task automatic cycle();
        bit         ea, eb, ewr, eva, evb;
        logic [9:0] eaddr;
        logic [7:0] edata;
        #2;
        ea = 0; eb = 0; ewr = 0;
        eaddr = m_haddr;
        edata = m_hdata;
        if (reset) begin
            eaddr = '0;
            edata = '0;
        end else if (m_clr) begin
            ewr   = 1;
            eaddr = m_cnt[9:0];
            edata = CV;
        end else begin
            if (req_a && req_b) begin
                ea = m_last_b;
                eb = !m_last_b;
            end else begin
                ea = req_a;
                eb = req_b;
            end
            if (ea) begin
                ewr = we_a; eaddr = addr_a; edata = wdata_a;
            end else if (eb) begin
                ewr = we_b; eaddr = addr_b; edata = wdata_b;
            end
        end
        eva = (rq.size() > 0) && (rq[0].due == cyc) && !rq[0].id;
        evb = (rq.size() > 0) && (rq[0].due == cyc) && rq[0].id;

        chk("busy", busy, m_clr);
        chk("gnt_a", gnt_a, ea);
        chk("gnt_b", gnt_b, eb);
        chk("ram_wren", ram_wren, ewr);
        chk("ram_address", ram_address, eaddr);
        chk("ram_data", ram_data, edata);
        chk("rvalid_a", rvalid_a, eva);
        chk("rvalid_b", rvalid_b, evb);
        if (eva) chk("rdata_a", rdata_a, rq[0].data);
        if (evb) chk("rdata_b", rdata_b, rq[0].data);

        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (reset) begin
            model_reset();
        end else if (m_clr) begin
            mem_ref[m_cnt] = CV;
            m_haddr = eaddr;
            m_hdata = edata;
            if (m_cnt == DEPTH - 1) begin
                m_clr = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (ea || eb) begin
                if (ewr) mem_ref[eaddr] = edata;
                else rq.push_back(ret_t'{due: cyc + 2, id: eb, data: mem_ref[eaddr]});
                m_haddr  = eaddr;
                m_hdata  = edata;
                m_last_b = eb;
            end
            if (clear) begin
                m_clr = 1;
                m_cnt = 0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        clear = 1'b0;
        if (ea) req_a = 1'b0;
        if (eb) req_b = 1'b0;
    endtask

    task automatic run_clear(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 1100) begin
            n++;
            cycle();
        end
        chk(tag, n, DEPTH);
    endtask

    function automatic logic [9:0] pick_addr();
        if ($urandom_range(3) == 0) return 10'($urandom);
        return 10'($urandom_range(15));
    endfunction

    task automatic rand_reqs();
        if (!req_a && $urandom_range(99) < 60) begin
            req_a = 1'b1; we_a = 1'($urandom_range(1));
            addr_a = pick_addr(); wdata_a = 8'($urandom);
        end
        if (!req_b && $urandom_range(99) < 60) begin
            req_b = 1'b1; we_b = 1'($urandom_range(1));
            addr_b = pick_addr(); wdata_b = 8'($urandom);
        end
    endtask

    task automatic set_a(input logic we, input logic [9:0] a, input logic [7:0] d);
        req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
    endtask

    task automatic set_b(input logic we, input logic [9:0] a, input logic [7:0] d);
        req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 8'($urandom);
        reset = 1'b1; clear = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        pa_reset = 1'b1; pa_req_a = 1'b0; pa_req_b = 1'b0; pa_ram_q = '0;
        cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;

        // Clear after reset, then read back a cleared word
        run_clear("t1_busy_len");
        set_b(1'b0, 10'h005, 8'h00);
        repeat (3) cycle();

        // Write by A then read of the same address by B
        set_a(1'b1, 10'h155, 8'h3C);
        cycle();
        set_b(1'b0, 10'h155, 8'h00);
        repeat (3) cycle();

        // Continuous reads from both: round-robin alternation
        set_a(1'b1, 10'h010, 8'hA1);
        set_b(1'b1, 10'h020, 8'hB2);
        repeat (2) cycle();
        for (int i = 0; i < 12; i++) begin
            set_a(1'b0, 10'h010, 8'h00);
            set_b(1'b0, 10'h020, 8'h00);
            cycle();
        end
        req_a = 1'b0; req_b = 1'b0;
        repeat (3) cycle();

        // Read granted in the same cycle as a clear pulse; B waits out the clear
        set_a(1'b1, 10'h0AA, 8'h77);
        cycle();
        set_a(1'b0, 10'h0AA, 8'h00);
        clear = 1'b1;
        cycle();
        set_b(1'b0, 10'h155, 8'h00);
        run_clear("t5_busy_len");
        #1;
        chk("t5_gnt_b_first_serve", gnt_b, 1'b1);
        repeat (4) cycle();

        // Reset drops an in-flight read, then reset mid-clear restarts it
        set_a(1'b0, 10'h0AA, 8'h00);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run_clear("t6_busy_after_reset");
        clear = 1'b1;
        cycle();
        repeat (500) cycle();
        #1;
        chk("t6_addr_at_500", ram_address, 10'd500);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run_clear("t6_busy_restart");

        // Random traffic with occasional clear pulses
        for (int i = 0; i < 3000; i++) begin
            rand_reqs();
            if ($urandom_range(999) == 0) clear = 1'b1;
            cycle();
        end
        req_a = 1'b0; req_b = 1'b0;
        repeat (4) cycle();
        while (busy === 1'b1 && cyc < 20000) cycle();
        repeat (3) cycle();

        // Fixed A priority on the second instance
        pa_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            pa_req_a = 1'b1; pa_req_b = 1'b1;
            #2;
            chk("t4_gnt_a_tie", pa_gnt_a, 1'b1);
            chk("t4_gnt_b_tie", pa_gnt_b, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        pa_req_a = 1'b0;
        #2;
        chk("t4_gnt_b_after_drop", pa_gnt_b, 1'b1);
        chk("t4_gnt_a_after_drop", pa_gnt_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        pa_req_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
